// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: request/ack data-memory handshake with timeout, byte-lane steering,
// load extension and write-back select. Optional misalignment trap under `MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [1:0]  memSizeIn,
    input  logic        loadUnsignedIn,
    input  logic        memToRegIn,
    input  logic        regwriteIn,
    input  logic [4:0]  registerIn,
    input  logic [31:0] PCNEWIn,
    input  logic [31:0] aluResultIn,
    input  logic [31:0] storeDataIn,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck,
    output logic        stall,
    output logic        busErr,
    output logic        alignErr,
    output logic        regwriteOut,
    output logic [31:0] writeDataOut,
    output logic [4:0]  registerOut,
    output logic [31:0] PCNEWOut
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t      state, state_n;
    logic [7:0]  wcnt, wcnt_n;
    logic        mem_op;
    logic        misaligned;
    logic        align_trap;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [31:0] load_val;

    // Lane offset in bytes; half and word accesses drop the low address bits they cannot use.
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   lane_offset = a;
            2'b01:   lane_offset = {a[1], 1'b0};
            default: lane_offset = 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] sx;
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            2'b00: begin
                sx = b;
                load_extend = uns ? {24'd0, sh[7:0]} : sx;
            end
            2'b01: begin
                sx = h;
                load_extend = uns ? {16'd0, sh[15:0]} : sx;
            end
            default: load_extend = sh;
        endcase
    endfunction

    assign mem_op   = memReadIn | memWriteIn;
    assign lane_off = lane_offset(memSizeIn, aluResultIn[1:0]);

    always_comb begin
        case (memSizeIn)
            2'b00:   lane_be = 4'b0001 << lane_off;
            2'b01:   lane_be = 4'b0011 << lane_off;
            default: lane_be = 4'b1111;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (memSizeIn == 2'b01) ? aluResultIn[0] :
                        (memSizeIn[1])       ? (aluResultIn[1:0] != 2'b00) : 1'b0;
`else
    assign misaligned = 1'b0;
`endif

    assign load_val     = load_extend(memRData, memSizeIn, lane_off, loadUnsignedIn);
    assign memAddr      = {aluResultIn[31:2], 2'b00};
    assign memWData     = (memSizeIn == 2'b00) ? {4{storeDataIn[7:0]}} :
                          (memSizeIn == 2'b01) ? {2{storeDataIn[15:0]}} : storeDataIn;
    assign memWe        = Reset & memWriteIn & ~memReadIn;
    assign memBe        = Reset ? lane_be : 4'b0000;
    assign writeDataOut = memToRegIn ? load_val : aluResultIn;
    assign registerOut  = registerIn;
    assign PCNEWOut     = PCNEWIn;
    assign alignErr     = align_trap;

    always_comb begin
        state_n     = state;
        wcnt_n      = wcnt;
        memReq      = 1'b0;
        stall       = 1'b0;
        busErr      = 1'b0;
        align_trap  = 1'b0;
        regwriteOut = 1'b0;
        if (Reset) begin
            case (state)
                S_IDLE: begin
                    if (!mem_op) begin
                        regwriteOut = regwriteIn;
                    end else if (misaligned) begin
                        align_trap = 1'b1;
                    end else begin
                        memReq = 1'b1;
                        if (memAck) begin
                            regwriteOut = regwriteIn;
                        end else begin
                            stall   = 1'b1;
                            state_n = S_WAIT;
                            wcnt_n  = 8'd1;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack wins over timeout when they land in the same cycle.
                    if (memAck) begin
                        memReq      = 1'b1;
                        regwriteOut = regwriteIn;
                        state_n     = S_IDLE;
                    end else if (wcnt == TO_LIMIT) begin
                        busErr  = 1'b1;
                        state_n = S_IDLE;
                        wcnt_n  = 8'd0;
                    end else begin
                        memReq = 1'b1;
                        stall  = 1'b1;
                        wcnt_n = wcnt + 8'd1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
            wcnt  <= 8'd0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage with TIMEOUT=4; expectations queued per cycle,
// a negedge monitor pops and compares them.
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        memReadIn, memWriteIn, loadUnsignedIn, memToRegIn, regwriteIn, memAck;
    logic [1:0]  memSizeIn;
    logic [4:0]  registerIn;
    logic [31:0] PCNEWIn, aluResultIn, storeDataIn, memRData;
    logic        memReq, memWe, stall, busErr, alignErr, regwriteOut;
    logic [3:0]  memBe;
    logic [4:0]  registerOut;
    logic [31:0] memAddr, memWData, writeDataOut, PCNEWOut;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [11:0] M_REQ = 12'h001, M_STL = 12'h002, M_BERR = 12'h004, M_AERR = 12'h008,
                            M_RW = 12'h010, M_WE = 12'h020, M_BE = 12'h040, M_WD = 12'h080,
                            M_ADDR = 12'h100, M_WDO = 12'h200, M_REG = 12'h400, M_PC = 12'h800;
    localparam logic [11:0] CTL = M_REQ | M_STL | M_BERR | M_AERR | M_RW;

    typedef struct {
        string       nm;
        logic [11:0] m;
        logic        req, stl, berr, aerr, rw, we;
        logic [3:0]  be;
        logic [31:0] wd, addr, wdo;
        logic [4:0]  rg;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    mem_access_stage #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Reset(Reset), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
        .memSizeIn(memSizeIn), .loadUnsignedIn(loadUnsignedIn), .memToRegIn(memToRegIn),
        .regwriteIn(regwriteIn), .registerIn(registerIn), .PCNEWIn(PCNEWIn),
        .aluResultIn(aluResultIn), .storeDataIn(storeDataIn), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memBe(memBe), .memWData(memWData), .memRData(memRData),
        .memAck(memAck), .stall(stall), .busErr(busErr), .alignErr(alignErr),
        .regwriteOut(regwriteOut), .writeDataOut(writeDataOut), .registerOut(registerOut),
        .PCNEWOut(PCNEWOut)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.m & M_REQ)  chk(e.nm, "memReq", {31'd0, memReq}, {31'd0, e.req});
            if (e.m & M_STL)  chk(e.nm, "stall", {31'd0, stall}, {31'd0, e.stl});
            if (e.m & M_BERR) chk(e.nm, "busErr", {31'd0, busErr}, {31'd0, e.berr});
            if (e.m & M_AERR) chk(e.nm, "alignErr", {31'd0, alignErr}, {31'd0, e.aerr});
            if (e.m & M_RW)   chk(e.nm, "regwriteOut", {31'd0, regwriteOut}, {31'd0, e.rw});
            if (e.m & M_WE)   chk(e.nm, "memWe", {31'd0, memWe}, {31'd0, e.we});
            if (e.m & M_BE)   chk(e.nm, "memBe", {28'd0, memBe}, {28'd0, e.be});
            if (e.m & M_WD)   chk(e.nm, "memWData", memWData, e.wd);
            if (e.m & M_ADDR) chk(e.nm, "memAddr", memAddr, e.addr);
            if (e.m & M_WDO)  chk(e.nm, "writeDataOut", writeDataOut, e.wdo);
            if (e.m & M_REG)  chk(e.nm, "registerOut", {27'd0, registerOut}, {27'd0, e.rg});
            if (e.m & M_PC)   chk(e.nm, "PCNEWOut", PCNEWOut, e.pc);
        end
    end

    task automatic push(input string nm, input logic [11:0] m, input logic req, input logic stl,
                        input logic berr, input logic aerr, input logic rw, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] addr,
                        input logic [31:0] wdo, input logic [4:0] rg, input logic [31:0] pc);
        exp_t e;
        e.nm = nm; e.m = m; e.req = req; e.stl = stl; e.berr = berr; e.aerr = aerr; e.rw = rw;
        e.we = we; e.be = be; e.wd = wd; e.addr = addr; e.wdo = wdo; e.rg = rg; e.pc = pc;
        sb.push_back(e);
    endtask

    // Control-only expectation shorthand.
    task automatic pctl(input string nm, input logic req, input logic stl, input logic berr,
                        input logic aerr, input logic rw);
        push(nm, CTL, req, stl, berr, aerr, rw, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic go();
        @(posedge Clk);
        #1;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic m2r, input logic rwi, input logic [31:0] alu,
                      input logic [31:0] st, input logic [31:0] rdata, input logic ack);
        memReadIn = rd; memWriteIn = wr; memSizeIn = sz; loadUnsignedIn = uns;
        memToRegIn = m2r; regwriteIn = rwi; aluResultIn = alu; storeDataIn = st;
        memRData = rdata; memAck = ack;
    endtask

    initial begin
        Reset = 1'b0; registerIn = 5'd7; PCNEWIn = 32'h0000_0400;
        op(1, 0, 2'b10, 0, 0, 1, 32'h0000_1234, 32'h0, 32'h0, 1);
        go();
        push("rst_load", CTL | M_WE | M_BE | M_ADDR | M_WDO | M_REG | M_PC, 0, 0, 0, 0, 0, 0,
             4'h0, 32'h0, 32'h0000_1234, 32'h0000_1234, 5'd7, 32'h0000_0400);
        go();
        op(0, 1, 2'b00, 0, 0, 1, 32'h0000_1235, 32'h0000_00A5, 32'h0, 1);
        push("rst_store", CTL | M_WE | M_BE | M_WD, 0, 0, 0, 0, 0, 0,
             4'h0, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd0, 32'h0);

        // Out of reset: zero-wait loads
        go(); Reset = 1'b1;
        op(1, 0, 2'b10, 0, 0, 1, 32'h0000_1234, 32'h0, 32'h0, 1);
        pctl("post_rst", 1, 0, 0, 0, 1);
        go();
        op(1, 0, 2'b00, 0, 1, 1, 32'h0000_1003, 32'h0, 32'h8000_0000, 1);
        push("lb_signed", CTL | M_BE | M_ADDR | M_WDO, 1, 0, 0, 0, 1, 0,
             4'b1000, 32'h0, 32'h0000_1000, 32'hFFFF_FF80, 5'd0, 32'h0);
        go();
        op(1, 0, 2'b00, 1, 1, 1, 32'h0000_1003, 32'h0, 32'h8000_0000, 1);
        push("lb_unsigned", CTL | M_BE | M_WDO, 1, 0, 0, 0, 1, 0,
             4'b1000, 32'h0, 32'h0, 32'h0000_0080, 5'd0, 32'h0);
        go();
        op(1, 0, 2'b01, 0, 1, 1, 32'h0000_0012, 32'h0, 32'h8001_0000, 1);
        push("lh_signed", CTL | M_BE | M_WDO, 1, 0, 0, 0, 1, 0,
             4'b1100, 32'h0, 32'h0, 32'hFFFF_8001, 5'd0, 32'h0);
        go();
        op(1, 0, 2'b01, 1, 1, 1, 32'h0000_0010, 32'h0, 32'h1234_ABCD, 1);
        push("lhu_low", CTL | M_BE | M_WDO, 1, 0, 0, 0, 1, 0,
             4'b0011, 32'h0, 32'h0, 32'h0000_ABCD, 5'd0, 32'h0);

        // Half store with three wait cycles
        go();
        op(0, 1, 2'b01, 0, 0, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0);
        push("sh_c1", CTL | M_WE | M_BE | M_WD | M_ADDR | M_WDO, 1, 1, 0, 0, 0, 1,
             4'b1100, 32'hABCD_ABCD, 32'h0000_2000, 32'h0000_2002, 5'd0, 32'h0);
        go(); pctl("sh_c2", 1, 1, 0, 0, 0);
        go(); pctl("sh_c3", 1, 1, 0, 0, 0);
        go(); memAck = 1'b1; pctl("sh_ack", 1, 0, 0, 0, 0);

        // Timeout: four stall cycles then abort
        go();
        op(1, 0, 2'b10, 0, 1, 1, 32'h0000_0040, 32'h0, 32'h0, 0);
        pctl("to_c1", 1, 1, 0, 0, 0);
        go(); pctl("to_c2", 1, 1, 0, 0, 0);
        go(); pctl("to_c3", 1, 1, 0, 0, 0);
        go(); pctl("to_c4", 1, 1, 0, 0, 0);
        go(); pctl("to_abort", 0, 0, 1, 0, 0);
        go();
        op(0, 0, 2'b10, 0, 0, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1);
        push("alu_after_to", CTL | M_WDO, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF,
             5'd0, 32'h0);

        // Ack coincident with the timeout cycle, then back-to-back load
        go();
        op(1, 0, 2'b10, 0, 1, 1, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 0);
        pctl("ackto_c1", 1, 1, 0, 0, 0);
        go(); pctl("ackto_c2", 1, 1, 0, 0, 0);
        go(); pctl("ackto_c3", 1, 1, 0, 0, 0);
        go(); pctl("ackto_c4", 1, 1, 0, 0, 0);
        go(); memAck = 1'b1;
        push("ackto_ack", CTL | M_WDO, 1, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 32'hCAFE_F00D,
             5'd0, 32'h0);
        go();
        op(1, 0, 2'b00, 0, 1, 1, 32'h0000_0055, 32'h0, 32'h1122_3344, 0);
        push("b2b_issue", CTL | M_BE, 1, 1, 0, 0, 0, 0, 4'b0010, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        go(); memAck = 1'b1;
        push("b2b_ack", CTL | M_WDO, 1, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 32'h0000_0033,
             5'd0, 32'h0);

        // Misaligned word load
        go();
        op(1, 0, 2'b10, 0, 1, 1, 32'h0000_3002, 32'h0, 32'h0, 1);
`ifdef MEM_ALIGN_CHECK_EN
        pctl("lw_misaligned", 0, 0, 0, 1, 0);
`else
        push("lw_misaligned", CTL | M_BE | M_ADDR, 1, 0, 0, 0, 1, 0, 4'b1111, 32'h0,
             32'h0000_3000, 32'h0, 5'd0, 32'h0);
`endif

        // Reset mid-access drops the request without busErr
        go();
        op(1, 0, 2'b10, 0, 1, 1, 32'h0000_0060, 32'h0, 32'h0, 0);
        pctl("rstmid_c1", 1, 1, 0, 0, 0);
        go(); Reset = 1'b0; pctl("rstmid_rst", 0, 0, 0, 0, 0);
        go(); Reset = 1'b1;
        op(0, 0, 2'b10, 0, 0, 1, 32'h0000_0064, 32'h0, 32'h0, 0);
        pctl("rstmid_idle", 0, 0, 0, 0, 1);

        go(); go();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
